// File: rtl/instr_loader_pkg.sv
// Shared widths, FSM states and error codes for the byte-stream program loader.
package instr_loader_pkg;

    localparam int unsigned IMEM_AW = 10;
    localparam int unsigned IW      = 9;
    // Frame word count is one bit wider than the address so a full 1024-word image is representable.
    localparam int unsigned CW      = IMEM_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_W_LO,
        S_W_HI,
        S_CHECK,
        S_DONE,
        S_ERR
    } ldr_state_t;

    typedef enum logic [1:0] {
        LE_NONE,
        LE_LEN,
        LE_FMT,
        LE_CSUM
    } ldr_err_t;

endpackage

// File: rtl/instr_loader.sv
// Program loader: unpacks a framed host byte stream into 9-bit instruction writes,
// holding the CPU while loading and checking length, word format and XOR checksum.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned SIZE = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               wr_en,
    output logic [IMEM_AW-1:0] wr_addr,
    output logic [IW-1:0]      wr_data,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    localparam logic [CW-1:0] SIZE_W = CW'(SIZE);

    ldr_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         lo_q, lo_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    ldr_err_t           err_code_q, err_code_d;
    logic               wr_en_q, wr_en_d;
    logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [IW-1:0]      wr_data_q, wr_data_d;

    logic               accept;
    logic [CW-1:0]      cnt_new;
    logic [CW-1:0]      idx_inc;

    assign accept  = rx_valid && rx_ready;
    assign cnt_new = {rx_data[2:0], cnt_q[7:0]};
    assign idx_inc = idx_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= LE_NONE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        lo_d       = lo_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_CNT_LO;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = LE_NONE;
                    csum_d     = '0;
                    idx_d      = '0;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d   = {3'b000, rx_data};
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_d  = cnt_new;
                    csum_d = csum_q ^ rx_data;
                    if (cnt_new > SIZE_W) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = LE_LEN;
                    end else if (cnt_new == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_W_HI;
                end
            end
            S_W_HI: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (rx_data[7:1] != 7'd0) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = LE_FMT;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q[IMEM_AW-1:0];
                        wr_data_d = {rx_data[0], lo_q};
                        idx_d     = idx_inc;
                        state_d   = (idx_inc == cnt_q) ? S_CHECK : S_W_LO;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = LE_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        cpu_hold = 1'b0;
        case (state_q)
            S_CNT_LO, S_CNT_HI, S_W_LO, S_W_HI, S_CHECK: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            default: begin
                rx_ready = 1'b0;
                cpu_hold = 1'b0;
            end
        endcase
    end

    assign busy     = cpu_hold;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed frame table, hand-written corner
// sequences and random frames checked against a frame-parsing reference model.
module tb_instr_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [8:0] wr_data;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    instr_loader #(.SIZE(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  frm[$];
    logic [18:0] exp_w[$];
    logic [18:0] got_w[$];
    logic        m_done, m_err;
    logic [1:0]  m_code;
    int          m_used;

    // Every write strobe seen between edges is one store write {addr, data}.
    always @(negedge clk) if (wr_en === 1'b1) got_w.push_back({wr_addr, wr_data});

    typedef struct {
        logic [7:0]  b [8];
        int          n;
        logic        e_done;
        logic        e_err;
        logic [1:0]  e_code;
        int          nwr;
        logic [18:0] w [2];
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bit acc;
        repeat (gap) cycle();
        rx_data  = b;
        rx_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = rx_ready;
            cycle();
        end
        rx_valid = 1'b0;
        ok = acc;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_accept_timeout: rx_ready stayed 0 for byte 0x%0h, required 1", b);
        end
    endtask

    task automatic run_frame(input int gmin, input int gmax);
        bit ok;
        pulse_start();
        for (int k = 0; k < frm.size(); k++) begin
            send_byte(frm[k], $urandom_range(gmax, gmin), ok);
            if (!ok) break;
        end
        repeat (3) cycle();
    endtask

    task automatic cmp_writes(input string tag);
        check($sformatf("%s_nwr", tag), got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), {13'd0, got_w[i]}, {13'd0, exp_w[i]});
    endtask

    task automatic check_flags(input string tag, input logic d, input logic e, input logic [1:0] c);
        check($sformatf("%s_done", tag), {31'd0, done}, {31'd0, d});
        check($sformatf("%s_error", tag), {31'd0, error}, {31'd0, e});
        check($sformatf("%s_err_code", tag), {30'd0, err_code}, {30'd0, c});
        check($sformatf("%s_idle_hold", tag), {30'd0, cpu_hold, busy}, 32'd0);
        check($sformatf("%s_idle_ready", tag), {31'd0, rx_ready}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {8'd0, rx_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, err_code},
              32'd0);
    endtask

    // Parse frm as a frame: expected writes, final flags and how many bytes the loader takes.
    task automatic ref_model();
        int         count;
        logic [7:0] lo, hi, x;
        exp_w.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_code = 2'd0;
        count  = {frm[1][2:0], frm[0]};
        m_used = 2;
        if (count > 1024) begin
            m_err  = 1'b1;
            m_code = 2'd1;
            return;
        end
        for (int k = 0; k < count; k++) begin
            lo = frm[2 + 2 * k];
            hi = frm[3 + 2 * k];
            m_used += 2;
            if (hi > 8'd1) begin
                m_err  = 1'b1;
                m_code = 2'd2;
                return;
            end
            exp_w.push_back({10'(k), hi[0], lo});
        end
        x = 8'd0;
        for (int i = 0; i < m_used; i++) x ^= frm[i];
        m_used++;
        if (frm[m_used - 1] == x) m_done = 1'b1;
        else begin
            m_err  = 1'b1;
            m_code = 2'd3;
        end
    endtask

    task automatic load_basic();
        frm.delete();
        frm = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A};
        exp_w.delete();
        exp_w.push_back({10'd0, 9'h1A5});
        exp_w.push_back({10'd1, 9'h03C});
    endtask

    initial begin
        bit          ok;
        int          cnt, kind;
        logic [7:0]  cs, hb, lb;

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        repeat (3) cycle();
        check_all_zero("reset_state");
        rst_n = 1'b1;
        cycle();

        tbl[0] = '{b: '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A, 8'h00}, n: 7,
                   e_done: 1, e_err: 0, e_code: 0, nwr: 2, w: '{{10'd0, 9'h1A5}, {10'd1, 9'h03C}}};
        tbl[1] = '{b: '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9B, 8'h00}, n: 7,
                   e_done: 0, e_err: 1, e_code: 3, nwr: 2, w: '{{10'd0, 9'h1A5}, {10'd1, 9'h03C}}};
        tbl[2] = '{b: '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2,
                   e_done: 0, e_err: 1, e_code: 1, nwr: 0, w: '{19'd0, 19'd0}};
        tbl[3] = '{b: '{8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4,
                   e_done: 0, e_err: 1, e_code: 2, nwr: 0, w: '{19'd0, 19'd0}};
        tbl[4] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3,
                   e_done: 1, e_err: 0, e_code: 0, nwr: 0, w: '{19'd0, 19'd0}};
        tbl[5] = '{b: '{8'h01, 8'hF8, 8'h12, 8'h01, 8'hEA, 8'h00, 8'h00, 8'h00}, n: 5,
                   e_done: 1, e_err: 0, e_code: 0, nwr: 1, w: '{{10'd0, 9'h112}, 19'd0}};
        tbl[6] = '{b: '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3,
                   e_done: 0, e_err: 1, e_code: 3, nwr: 0, w: '{19'd0, 19'd0}};
        tbl[7] = '{b: '{8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h03, 8'h00, 8'h00}, n: 6,
                   e_done: 0, e_err: 1, e_code: 2, nwr: 1, w: '{{10'd0, 9'h011}, 19'd0}};

        for (int i = 0; i < 8; i++) begin
            frm.delete();
            for (int k = 0; k < tbl[i].n; k++) frm.push_back(tbl[i].b[k]);
            exp_w.delete();
            for (int k = 0; k < tbl[i].nwr; k++) exp_w.push_back(tbl[i].w[k]);
            got_w.delete();
            run_frame(0, 0);
            cmp_writes($sformatf("tbl%0d", i));
            check_flags($sformatf("tbl%0d", i), tbl[i].e_done, tbl[i].e_err, tbl[i].e_code);
        end

        // Write latency and cpu_hold release on the basic frame.
        load_basic();
        got_w.delete();
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(frm[k], 0, ok);
        check("lat_wr_en", {31'd0, wr_en}, 32'd1);
        check("lat_wr_word", {13'd0, wr_addr, wr_data}, {13'd0, 10'd0, 9'h1A5});
        send_byte(frm[4], 0, ok);
        check("lat_wr_en_one_cycle", {31'd0, wr_en}, 32'd0);
        send_byte(frm[5], 0, ok);
        check("hold_before_last", {30'd0, cpu_hold, busy}, 32'd3);
        send_byte(frm[6], 0, ok);
        check("hold_after_last", {30'd0, cpu_hold, busy}, 32'd0);
        check("done_after_last", {31'd0, done}, 32'd1);
        repeat (2) cycle();
        cmp_writes("lat");

        // Start while busy, alone and together with an accepted byte, is ignored.
        load_basic();
        got_w.delete();
        pulse_start();
        send_byte(frm[0], 0, ok);
        send_byte(frm[1], 0, ok);
        pulse_start();
        start = 1'b1;
        send_byte(frm[2], 0, ok);
        start = 1'b0;
        for (int k = 3; k < 7; k++) send_byte(frm[k], 0, ok);
        repeat (3) cycle();
        cmp_writes("busy_start");
        check_flags("busy_start", 1'b1, 1'b0, 2'd0);

        // Throttled source: one valid cycle in three.
        load_basic();
        got_w.delete();
        run_frame(2, 2);
        cmp_writes("throttle");
        check_flags("throttle", 1'b1, 1'b0, 2'd0);

        // Reset right after the first word's hi byte.
        load_basic();
        got_w.delete();
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(frm[k], 0, ok);
        rst_n = 1'b0;
        cycle();
        check_all_zero("midreset_outputs");
        rst_n = 1'b1;
        repeat (5) cycle();
        exp_w.delete();
        exp_w.push_back({10'd0, 9'h1A5});
        cmp_writes("midreset");
        check_flags("midreset", 1'b0, 1'b0, 2'd0);

        // Full-size image: addresses 0..1023, no wrap.
        frm.delete();
        frm.push_back(8'h00);
        frm.push_back(8'h04);
        for (int k = 0; k < 1024; k++) begin
            frm.push_back(8'($urandom_range(0, 255)));
            frm.push_back(8'($urandom_range(0, 1)));
        end
        cs = 8'd0;
        for (int k = 0; k < frm.size(); k++) cs ^= frm[k];
        frm.push_back(cs);
        ref_model();
        got_w.delete();
        run_frame(0, 0);
        cmp_writes("full");
        check_flags("full", m_done, m_err, m_code);

        // Random frames against the reference model.
        for (int r = 0; r < 40; r++) begin
            frm.delete();
            cnt  = $urandom_range(0, 6);
            kind = $urandom_range(0, 9);
            hb   = 8'($urandom_range(0, 31)) << 3;
            if (kind == 0) begin
                cnt = 1025 + $urandom_range(0, 1022);
                frm.push_back(8'(cnt));
                frm.push_back(hb | 8'(cnt >> 8));
            end else begin
                frm.push_back(8'(cnt));
                frm.push_back(hb);
                for (int k = 0; k < cnt; k++) begin
                    lb = 8'($urandom_range(0, 255));
                    frm.push_back(lb);
                    if (kind == 1 && k == cnt - 1) frm.push_back(8'($urandom_range(2, 255)));
                    else frm.push_back(8'($urandom_range(0, 1)));
                end
                cs = 8'd0;
                for (int k = 0; k < frm.size(); k++) cs ^= frm[k];
                if (kind == 2) cs ^= 8'($urandom_range(1, 255));
                frm.push_back(cs);
            end
            ref_model();
            while (frm.size() > m_used) void'(frm.pop_back());
            got_w.delete();
            run_frame(0, 3);
            cmp_writes($sformatf("rnd%0d", r));
            check_flags($sformatf("rnd%0d", r), m_done, m_err, m_code);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
